// File: rtl/hex_display_pio.sv
// hex_display_pio: Avalon-MM hex-digit output PIO with set/clear, blanking and hardware blink.
// Ports: clk, reset_n (sync, active-low); address/chipselect/write_n/writedata/readdata slave bus;
// out_port = DATA digit codes (digit i at [4i+3:4i]); digit_en = registered per-digit enable.
// Macro HEX_DISPLAY_PIO_BLINK_EN builds the blink timer, BLINK register and STATUS phase bit.
module hex_display_pio #(
  parameter int          NUM_DIGITS  = 4,
  parameter int          BLINK_DIV   = 25000000,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [4*NUM_DIGITS-1:0] out_port,
  output logic [NUM_DIGITS-1:0]   digit_en
);
  localparam int DW = 4 * NUM_DIGITS;
  logic                  we;
  logic [DW-1:0]         wd;
  logic [DW-1:0]         data_q, data_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic [NUM_DIGITS-1:0] blink_r;
  logic                  phase;
  assign we = chipselect && !write_n;
  assign wd = writedata[DW-1:0];
`ifdef HEX_DISPLAY_PIO_BLINK_EN
  typedef enum logic {LIT, DARK} state_t;
  localparam int CW = $clog2(BLINK_DIV);
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0] blink_q, blink_d;
  logic                  blink_wr, wrap;
  always_comb begin
    blink_wr = we && address == 3'd2;
    wrap     = cnt_q == CW'(BLINK_DIV - 1);
    blink_d  = blink_wr ? writedata[NUM_DIGITS-1:0] : blink_q;
    // A BLINK write restarts the lit half and overrides a coincident wrap.
    cnt_d    = (blink_wr || wrap) ? '0 : cnt_q + CW'(1);
    state_d  = blink_wr ? LIT : !wrap ? state_q : (state_q == LIT) ? DARK : LIT;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= LIT;
      cnt_q   <= '0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end
  assign phase   = state_q == DARK;
  assign blink_r = blink_q;
`else
  assign phase   = 1'b0;
  assign blink_r = '0;
`endif
  always_comb begin
    data_d  = (we && address == 3'd0) ? wd :
              (we && address == 3'd4) ? (data_q | wd) :
              (we && address == 3'd5) ? (data_q & ~wd) : data_q;
    blank_d = (we && address == 3'd1) ? writedata[NUM_DIGITS-1:0] : blank_q;
    en_d    = ~blank_q & ~(blink_r & {NUM_DIGITS{phase}});
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q  <= RESET_VALUE[DW-1:0];
      blank_q <= '0;
      en_q    <= '1;
    end else begin
      data_q  <= data_d;
      blank_q <= blank_d;
      en_q    <= en_d;
    end
  end
  always_comb begin
    readdata = (address == 3'd0) ? 32'(data_q) :
               (address == 3'd1) ? 32'(blank_q) :
               (address == 3'd2) ? 32'(blink_r) :
               (address == 3'd3) ? {31'd0, phase} : 32'd0;
  end
  assign out_port = data_q;
  assign digit_en = en_q;
endmodule

// File: tb/tb_hex_display_pio.sv
// tb_hex_display_pio: self-checking bench for hex_display_pio with a cycle-count blink model.
module tb_hex_display_pio;
  localparam int ND = 4;
  localparam int BD = 4;
  localparam logic [31:0] RV = 32'h1234;
`ifdef HEX_DISPLAY_PIO_BLINK_EN
  localparam bit BEN = 1'b1;
`else
  localparam bit BEN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [15:0] out_port;
  logic [3:0]  digit_en;
  int checks = 0;
  int errors = 0;
  hex_display_pio #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .digit_en(digit_en)
  );
  always #5 clk = ~clk;
  // Model: blink phase is derived from the number of edges since the last restart.
  logic [15:0] m_data;
  logic [3:0]  m_blank, m_blink, m_en;
  int          m_k;
  bit          m_valid = 1'b0;
  function automatic bit m_phase(input int k);
    return BEN ? bit'((k / BD) % 2) : 1'b0;
  endfunction
  function automatic logic [31:0] m_read(input logic [2:0] a);
    return a == 3'd0 ? {16'd0, m_data} : a == 3'd1 ? {28'd0, m_blank} :
           a == 3'd2 ? {28'd0, m_blink} : a == 3'd3 ? {31'd0, m_phase(m_k)} : 32'd0;
  endfunction
  always @(posedge clk) begin
    if (!reset_n) begin
      m_data = RV[15:0]; m_blank = 4'd0; m_blink = 4'd0; m_k = 0; m_en = 4'hF; m_valid = 1'b1;
    end else begin
      m_en = ~m_blank & ~(m_blink & {4{m_phase(m_k)}});
      m_k = m_k + 1;
      if (chipselect && !write_n) begin
        if (address == 3'd0) m_data = writedata[15:0];
        if (address == 3'd1) m_blank = writedata[3:0];
        if (address == 3'd2 && BEN) begin m_blink = writedata[3:0]; m_k = 0; end
        if (address == 3'd4) m_data = m_data | writedata[15:0];
        if (address == 3'd5) m_data = m_data & ~writedata[15:0];
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      chk("model_out_port", {16'd0, out_port}, {16'd0, m_data});
      chk("model_digit_en", {28'd0, digit_en}, {28'd0, m_en});
      chk("model_readdata", readdata, m_read(address));
    end
  end
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask
  task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(name, readdata, exp);
  endtask
  task automatic measure(input logic [3:0] v, output int n);
    n = 0;
    while (digit_en == v && n < 20) begin n++; @(negedge clk); end
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_out_port", {16'd0, out_port}, 32'h1234);
    chk("rst_digit_en", {28'd0, digit_en}, 32'hF);
    rd("rst_rd0", 3'd0, 32'h1234);
    rd("rst_rd1", 3'd1, 32'h0);
    rd("rst_rd2", 3'd2, 32'h0);
    rd("rst_rd3", 3'd3, 32'h0);
    wr(3'd0, 32'h00F0);
    chk("set_step0", {16'd0, out_port}, 32'h00F0);
    wr(3'd4, 32'h0F01);
    chk("set_step1", {16'd0, out_port}, 32'h0FF1);
    wr(3'd5, 32'h00F0);
    chk("clr_step2", {16'd0, out_port}, 32'h0F01);
    rd("rd_outset", 3'd4, 32'h0);
    rd("rd_outclear", 3'd5, 32'h0);
    wr(3'd0, 32'hABCD5678);
    chk("mask_out_port", {16'd0, out_port}, 32'h5678);
    rd("mask_rd0", 3'd0, 32'h00005678);
    wr(3'd7, 32'hFFFFFFFF);
    chk("rsvd_out_port", {16'd0, out_port}, 32'h5678);
    rd("rsvd_rd0", 3'd0, 32'h00005678);
    rd("rsvd_rd7", 3'd7, 32'h0);
`ifdef HEX_DISPLAY_PIO_BLINK_EN
    wr(3'd2, 32'h2);
    wr(3'd1, 32'h8);
    address = 3'd3;
    n = 0;
    while (digit_en != 4'h5 && n < 20) begin n++; @(negedge clk); end
    chk("blink_reach_dark", {31'd0, n < 20}, 32'd1);
    rd("status_dark", 3'd3, 32'h1);
    measure(4'h5, n);
    chk("blink_dark_len", n, 32'd4);
    measure(4'h7, n);
    chk("blink_lit_len", n, 32'd4);
    wr(3'd2, 32'h2);
    n = 0;
    while (digit_en != 4'h7 && n < 5) begin n++; @(negedge clk); end
    chk("rewrite_restore", {31'd0, n <= 2}, 32'd1);
    measure(4'h7, n);
    chk("rewrite_lit_len", n, 32'd4);
    chk("rewrite_dark_again", {28'd0, digit_en}, 32'h5);
`endif
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midrst_digit_en", {28'd0, digit_en}, 32'hF);
    chk("midrst_out_port", {16'd0, out_port}, 32'h1234);
    rd("midrst_status", 3'd3, 32'h0);
    measure(4'hF, n);
    chk("midrst_no_blink", n, 32'd20);
`ifndef HEX_DISPLAY_PIO_BLINK_EN
    wr(3'd2, 32'hF);
    rd("noblink_rd2", 3'd2, 32'h0);
    rd("noblink_rd3", 3'd3, 32'h0);
    measure(4'hF, n);
    chk("noblink_steady", n, 32'd20);
    wr(3'd1, 32'h1);
    @(negedge clk);
    chk("noblink_blank", {28'd0, digit_en}, 32'hE);
`endif
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
